// File: rtl/register_file_sb.sv
// Multi-port register file with write-first read bypass and a per-register
// busy scoreboard tracking destinations of issued, not yet written-back instructions.
module register_file_sb #(
   parameter int REG_COUNT    = 16,
   parameter int REG_SIZE     = 8,
   parameter int REG_PTR_SIZE = 4,
   parameter int RD_PORTS     = 3,
   parameter int WR_PORTS     = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             init_R0,
   input  logic [REG_SIZE-1:0]              init_R0_data,
   input  logic [RD_PORTS*REG_PTR_SIZE-1:0] rd_addr,
   output logic [RD_PORTS*REG_SIZE-1:0]     rd_data,
   output logic [RD_PORTS-1:0]              rd_busy,
   input  logic [WR_PORTS-1:0]              wr_en,
   input  logic [WR_PORTS*REG_PTR_SIZE-1:0] wr_addr,
   input  logic [WR_PORTS*REG_SIZE-1:0]     wr_data,
   input  logic                             issue_en,
   input  logic [REG_PTR_SIZE-1:0]          issue_dst,
   output logic                             issue_stall,
   output logic [REG_COUNT-1:0]             busy_vec,
   output logic [REG_PTR_SIZE:0]            busy_count
);

   localparam int CW = REG_PTR_SIZE + 1;

   logic [REG_SIZE-1:0]  regs   [REG_COUNT];
   logic [REG_SIZE-1:0]  wr_val [REG_COUNT];
   logic [REG_COUNT-1:0] wr_hit;
   logic [REG_COUNT-1:0] busy;
   logic [REG_COUNT-1:0] eff_busy;
   logic [REG_COUNT-1:0] issue_set;

   // Per-register winning write: later (higher) ports overwrite earlier ones, init_R0 beats all.
   always_comb begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
         wr_hit[i] = 1'b0;
         wr_val[i] = '0;
         for (int unsigned k = 0; k < WR_PORTS; k++) begin
            if (wr_en[k] && (wr_addr[k*REG_PTR_SIZE +: REG_PTR_SIZE] == REG_PTR_SIZE'(i))) begin
               wr_hit[i] = 1'b1;
               wr_val[i] = wr_data[k*REG_SIZE +: REG_SIZE];
            end
         end
      end
      if (init_R0) begin
         wr_hit[0] = 1'b1;
         wr_val[0] = init_R0_data;
      end
   end

   assign eff_busy    = busy & ~wr_hit;
   assign issue_stall = issue_en & eff_busy[issue_dst];

   always_comb begin
      issue_set = '0;
      if (issue_en && !issue_stall)
         issue_set[issue_dst] = 1'b1;
   end

   // Bypassed data is masked during reset so reads show zero while reset is held.
   always_comb begin
      logic [REG_PTR_SIZE-1:0] a;
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned p = 0; p < RD_PORTS; p++) begin
         a = rd_addr[p*REG_PTR_SIZE +: REG_PTR_SIZE];
         if (reset_n)
            rd_data[p*REG_SIZE +: REG_SIZE] = wr_hit[a] ? wr_val[a] : regs[a];
         rd_busy[p] = eff_busy[a];
      end
   end

   always_comb begin
      busy_count = '0;
      for (int unsigned i = 0; i < REG_COUNT; i++)
         busy_count = busy_count + CW'(busy[i]);
   end

   assign busy_vec = busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < REG_COUNT; i++)
            regs[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < REG_COUNT; i++)
            if (wr_hit[i])
               regs[i] <= wr_val[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy <= '0;
      end else begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (issue_set[i])
               busy[i] <= 1'b1;
            else if (wr_hit[i])
               busy[i] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed scenarios plus random
// traffic checked against an array-based reference model.
module tb_register_file_sb;

   localparam int RC = 16;
   localparam int RS = 8;
   localparam int PS = 4;
   localparam int RP = 3;
   localparam int WP = 2;

   logic            clk;
   logic            reset_n;
   logic            init_R0;
   logic [RS-1:0]   init_R0_data;
   logic [RP*PS-1:0] rd_addr;
   logic [RP*RS-1:0] rd_data;
   logic [RP-1:0]   rd_busy;
   logic [WP-1:0]   wr_en;
   logic [WP*PS-1:0] wr_addr;
   logic [WP*RS-1:0] wr_data;
   logic            issue_en;
   logic [PS-1:0]   issue_dst;
   logic            issue_stall;
   logic [RC-1:0]   busy_vec;
   logic [PS:0]     busy_count;

   int tests = 0;
   int fails = 0;

   logic [RS-1:0] m_reg [RC];
   logic [RC-1:0] m_busy;

   register_file_sb #(
      .REG_COUNT(RC), .REG_SIZE(RS), .REG_PTR_SIZE(PS), .RD_PORTS(RP), .WR_PORTS(WP)
   ) dut (
      .clk(clk), .reset_n(reset_n), .init_R0(init_R0), .init_R0_data(init_R0_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_en(issue_en), .issue_dst(issue_dst), .issue_stall(issue_stall),
      .busy_vec(busy_vec), .busy_count(busy_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: the highest-numbered enabled port naming idx wins, init_R0 overrides for R0.
   function automatic void model_write(input int idx, output bit hit, output logic [RS-1:0] val);
      hit = 0;
      val = '0;
      if (init_R0 && idx == 0) begin
         hit = 1;
         val = init_R0_data;
         return;
      end
      for (int k = WP - 1; k >= 0; k--) begin
         if (wr_en[k] && int'(wr_addr[k*PS +: PS]) == idx) begin
            hit = 1;
            val = wr_data[k*RS +: RS];
            return;
         end
      end
   endfunction

   function automatic bit exp_eff_busy(input int idx);
      bit h;
      logic [RS-1:0] v;
      model_write(idx, h, v);
      return m_busy[idx] && !h;
   endfunction

   function automatic logic [RS-1:0] exp_rd(input int p);
      bit h;
      logic [RS-1:0] v;
      int a;
      a = int'(rd_addr[p*PS +: PS]);
      model_write(a, h, v);
      if (!reset_n) return '0;
      return h ? v : m_reg[a];
   endfunction

   function automatic bit exp_stall();
      return issue_en && exp_eff_busy(int'(issue_dst));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < RC; i++) m_reg[i] = '0;
      m_busy = '0;
   endtask

   task automatic clear_inputs();
      init_R0 = 0; init_R0_data = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      issue_en = 0; issue_dst = '0;
   endtask

   // Compute next model state from the inputs held across the edge, then advance to the next negedge.
   task automatic tick();
      logic [RS-1:0] nr [RC];
      logic [RC-1:0] nb;
      bit h;
      logic [RS-1:0] v;
      bit st;
      st = exp_stall();
      for (int i = 0; i < RC; i++) begin
         model_write(i, h, v);
         nr[i] = h ? v : m_reg[i];
         if (issue_en && !st && int'(issue_dst) == i) nb[i] = 1'b1;
         else if (h) nb[i] = 1'b0;
         else nb[i] = m_busy[i];
      end
      @(posedge clk);
      if (reset_n) begin
         m_reg = nr;
         m_busy = nb;
      end else begin
         model_reset();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if (rd_data !== '0 || rd_busy !== '0 || issue_stall !== 1'b0 || busy_vec !== '0 || busy_count !== '0) begin
         fails++;
         $display("FAIL reset_held: rd_data=%h rd_busy=%b stall=%b busy_vec=%h count=%0d, required all zero",
                  rd_data, rd_busy, issue_stall, busy_vec, busy_count);
      end
      @(negedge clk);
      reset_n = 1;
      wr_en = 2'b01; wr_addr = {4'd0, 4'd3}; wr_data = {8'h00, 8'h5A};
      tick();
      clear_inputs();
      issue_en = 1; issue_dst = 4'd3;
      tick();
      clear_inputs();
      rd_addr = {4'd0, 4'd0, 4'd3};
      #1;
      tests++;
      if (rd_data[7:0] !== 8'h5A || busy_count !== 5'd1) begin
         fails++;
         $display("FAIL reset_prewrite: rd=%h count=%0d, required 5a and 1", rd_data[7:0], busy_count);
      end
      #1;
      reset_n = 0;
      model_reset();
      #1;
      tests++;
      if (rd_data[7:0] !== 8'h00 || busy_vec !== '0 || busy_count !== '0) begin
         fails++;
         $display("FAIL reset_midcycle: rd=%h busy_vec=%h count=%0d, required 0", rd_data[7:0], busy_vec, busy_count);
      end
      @(negedge clk);
      reset_n = 1;
      #1;
      tests++;
      if (rd_data[7:0] !== 8'h00) begin
         fails++;
         $display("FAIL reset_cleared_R3: rd=%h, required 00", rd_data[7:0]);
      end
   endtask

   task automatic test_bypass();
      clear_inputs();
      wr_en = 2'b01; wr_addr = {4'd0, 4'd5}; wr_data = {8'h00, 8'h11};
      rd_addr = {4'd0, 4'd5, 4'd0};
      #1;
      tests++;
      if (rd_data[15:8] !== 8'h11) begin
         fails++;
         $display("FAIL bypass_same_cycle: rd1=%h, required 11", rd_data[15:8]);
      end
      tick();
      clear_inputs();
      #1;
      tests++;
      if (rd_data[15:8] !== 8'h11) begin
         fails++;
         $display("FAIL bypass_stored: rd1=%h, required 11", rd_data[15:8]);
      end
   endtask

   task automatic test_priority();
      clear_inputs();
      wr_en = 2'b11; wr_addr = {4'd7, 4'd7}; wr_data = {8'hBB, 8'hAA};
      rd_addr = {4'd7, 4'd0, 4'd0};
      #1;
      tests++;
      if (rd_data[23:16] !== 8'hBB) begin
         fails++;
         $display("FAIL prio_bypass: rd2=%h, required bb", rd_data[23:16]);
      end
      tick();
      clear_inputs();
      #1;
      tests++;
      if (rd_data[23:16] !== 8'hBB) begin
         fails++;
         $display("FAIL prio_stored: rd2=%h, required bb", rd_data[23:16]);
      end
      init_R0 = 1; init_R0_data = 8'h33;
      wr_en = 2'b11; wr_addr = {4'd0, 4'd0}; wr_data = {8'h55, 8'h44};
      rd_addr = {4'd7, 4'd0, 4'd0};
      #1;
      tests++;
      if (rd_data[7:0] !== 8'h33) begin
         fails++;
         $display("FAIL init_r0_bypass: rd0=%h, required 33", rd_data[7:0]);
      end
      tick();
      clear_inputs();
      #1;
      tests++;
      if (rd_data[7:0] !== 8'h33) begin
         fails++;
         $display("FAIL init_r0_stored: rd0=%h, required 33", rd_data[7:0]);
      end
   endtask

   task automatic test_scoreboard();
      clear_inputs();
      issue_en = 1; issue_dst = 4'd4;
      #1;
      tests++;
      if (issue_stall !== 1'b0) begin
         fails++;
         $display("FAIL sb_first_issue: stall=%b, required 0", issue_stall);
      end
      tick();
      clear_inputs();
      rd_addr = {4'd0, 4'd0, 4'd4};
      #1;
      tests++;
      if (busy_vec[4] !== 1'b1 || rd_busy[0] !== 1'b1) begin
         fails++;
         $display("FAIL sb_busy_set: busy4=%b rd_busy0=%b, required 1 1", busy_vec[4], rd_busy[0]);
      end
      issue_en = 1; issue_dst = 4'd4;
      #1;
      tests++;
      if (issue_stall !== 1'b1) begin
         fails++;
         $display("FAIL sb_waw_stall: stall=%b, required 1", issue_stall);
      end
      tick();
      wr_en = 2'b01; wr_addr = {4'd0, 4'd4}; wr_data = {8'h00, 8'h77};
      #1;
      tests++;
      if (issue_stall !== 1'b0 || rd_busy[0] !== 1'b0) begin
         fails++;
         $display("FAIL sb_wb_resolves: stall=%b rd_busy0=%b, required 0 0", issue_stall, rd_busy[0]);
      end
      tick();
      clear_inputs();
      #1;
      tests++;
      if (busy_vec[4] !== 1'b1 || rd_data[7:0] !== 8'h77) begin
         fails++;
         $display("FAIL sb_set_wins: busy4=%b rd0=%h, required 1 77", busy_vec[4], rd_data[7:0]);
      end
      wr_en = 2'b10; wr_addr = {4'd4, 4'd0}; wr_data = {8'h78, 8'h00};
      tick();
      clear_inputs();
      #1;
      tests++;
      if (busy_vec !== '0) begin
         fails++;
         $display("FAIL sb_clear: busy_vec=%h, required 0000", busy_vec);
      end
   endtask

   task automatic test_count();
      clear_inputs();
      for (int r = 1; r <= 3; r++) begin
         issue_en = 1; issue_dst = PS'(r);
         tick();
      end
      clear_inputs();
      #1;
      tests++;
      if (busy_count !== 5'd3) begin
         fails++;
         $display("FAIL count_three: count=%0d, required 3", busy_count);
      end
      wr_en = 2'b01; wr_addr = {4'd0, 4'd2}; wr_data = {8'h00, 8'h22};
      tick();
      clear_inputs();
      #1;
      tests++;
      if (busy_count !== 5'd2 || busy_vec !== 16'h000A) begin
         fails++;
         $display("FAIL count_after_wb: count=%0d vec=%h, required 2 000a", busy_count, busy_vec);
      end
      wr_en = 2'b01; wr_addr = {4'd0, 4'd9}; wr_data = {8'h00, 8'h99};
      tick();
      clear_inputs();
      rd_addr = {4'd0, 4'd9, 4'd0};
      #1;
      tests++;
      if (rd_data[15:8] !== 8'h99 || busy_count !== 5'd2) begin
         fails++;
         $display("FAIL count_nonbusy_write: rd1=%h count=%0d, required 99 2", rd_data[15:8], busy_count);
      end
   endtask

   task automatic test_random();
      int nfail_print;
      nfail_print = 0;
      for (int c = 0; c < 10000; c++) begin
         clear_inputs();
         if ($urandom_range(0, 299) == 0) begin
            reset_n = 0;
            model_reset();
         end else begin
            reset_n = 1;
         end
         wr_en = WP'($urandom_range(0, 3));
         for (int k = 0; k < WP; k++) begin
            wr_addr[k*PS +: PS] = PS'($urandom_range(0, RC - 1));
            wr_data[k*RS +: RS] = RS'($urandom);
         end
         init_R0 = ($urandom_range(0, 15) == 0);
         init_R0_data = RS'($urandom);
         issue_en = $urandom_range(0, 1) == 1;
         issue_dst = PS'($urandom_range(0, RC - 1));
         for (int p = 0; p < RP; p++) rd_addr[p*PS +: PS] = PS'($urandom_range(0, RC - 1));
         #1;
         for (int p = 0; p < RP; p++) begin
            tests++;
            if (rd_data[p*RS +: RS] !== exp_rd(p) ||
                rd_busy[p] !== (reset_n && exp_eff_busy(int'(rd_addr[p*PS +: PS])))) begin
               fails++;
               if (nfail_print++ < 20)
                  $display("FAIL rand_read cyc=%0d port=%0d: data=%h busy=%b, required %h %b", c, p,
                           rd_data[p*RS +: RS], rd_busy[p], exp_rd(p), exp_eff_busy(int'(rd_addr[p*PS +: PS])));
            end
         end
         tests++;
         if (issue_stall !== exp_stall() || busy_vec !== m_busy || busy_count !== 5'($countones(m_busy))) begin
            fails++;
            if (nfail_print++ < 20)
               $display("FAIL rand_sb cyc=%0d: stall=%b vec=%h count=%0d, required %b %h %0d", c,
                        issue_stall, busy_vec, busy_count, exp_stall(), m_busy, $countones(m_busy));
         end
         tick();
      end
      reset_n = 1;
      clear_inputs();
   endtask

   initial begin
      reset_n = 0;
      rd_addr = '0;
      clear_inputs();
      model_reset();
      test_reset();
      test_bypass();
      test_priority();
      test_scoreboard();
      test_count();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
